// File: rtl/sub_pipe_w_if.sv
// rtl/sub_pipe_w_if.sv - operand/result stream bundle for the pipelined subtractor
//
// Purpose: groups the input beat (a, b, borrow-in) and the result beat
// (dif, borrow-out, overflow, zero) with their valid/ready handshakes.
// Ports (seen from the subtractor, modport slave):
//   in_valid_i / in_ready_o : operand beat handshake
//   a_i, b_i, brw_i         : minuend, subtrahend, borrow-in
//   out_valid_o / out_ready_i : result beat handshake
//   dif_o, brw_o, ovf_o, zero_o : difference and flags
// modport master is the producer/consumer side driving that unit.
interface sub_pipe_w_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             brw_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] dif_o;
  logic             brw_o;
  logic             ovf_o;
  logic             zero_o;

  modport slave (
    input  in_valid_i, a_i, b_i, brw_i, out_ready_i,
    output in_ready_o, out_valid_o, dif_o, brw_o, ovf_o, zero_o
  );

  modport master (
    output in_valid_i, a_i, b_i, brw_i, out_ready_i,
    input  in_ready_o, out_valid_o, dif_o, brw_o, ovf_o, zero_o
  );
endinterface

// File: rtl/sub_pipe_w.sv
// rtl/sub_pipe_w.sv - W-bit subtractor pipelined as a chain of borrow-ripple slices
//
// Purpose: dif = (a - b - brw) mod 2^WIDTH with unsigned borrow-out, signed
// overflow and zero flags. Each stage resolves STAGE_BITS of the difference
// and registers it; NUM_STAGES = WIDTH / STAGE_BITS.
// Ports:
//   clk_i   : clock, all state on the rising edge
//   rst_ni  : asynchronous active-low reset
//   flush_i : synchronous flush, drops every in-flight beat
//   s_if    : operand/result stream bundle (sub_pipe_w_if.slave)
module sub_pipe_w #(
  parameter int WIDTH      = 16,
  parameter int STAGE_BITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  sub_pipe_w_if.slave s_if
);
  localparam int NUM_STAGES = WIDTH / STAGE_BITS;
  localparam int LAST       = NUM_STAGES - 1;

  logic w_en;
  logic w_out_vld;

  // Whole pipe advances together; bubbles are held, not squeezed out.
  assign w_en            = !w_out_vld || s_if.out_ready_i;
  assign s_if.in_ready_o = w_en;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    // REM: operand bits still unresolved entering this stage (lowest slice is ours).
    // DONE: difference bits resolved once this stage has registered.
    localparam int REM  = WIDTH - k * STAGE_BITS;
    localparam int DONE = (k + 1) * STAGE_BITS;

    logic [REM-1:0]      w_a;
    logic [REM-1:0]      w_b;
    logic                w_brw_in;
    logic                w_vld_in;
    logic [STAGE_BITS:0] w_slice;
    logic [DONE-1:0]     w_dif;
    logic                w_load;

    logic                r_vld;
    logic                r_brw;
    logic [DONE-1:0]     r_dif;

    if (k == 0) begin : g_head
      assign w_a      = s_if.a_i;
      assign w_b      = s_if.b_i;
      assign w_brw_in = s_if.brw_i;
      assign w_vld_in = s_if.in_valid_i;
      assign w_dif    = w_slice[STAGE_BITS-1:0];
    end else begin : g_body
      assign w_a      = g_stage[k-1].g_skew.r_a;
      assign w_b      = g_stage[k-1].g_skew.r_b;
      assign w_brw_in = g_stage[k-1].r_brw;
      assign w_vld_in = g_stage[k-1].r_vld;
      assign w_dif    = {w_slice[STAGE_BITS-1:0], g_stage[k-1].r_dif};
    end

    // One extra bit on the left: it reads 1 exactly when the slice borrows.
    assign w_slice = {1'b0, w_a[STAGE_BITS-1:0]}
                   - {1'b0, w_b[STAGE_BITS-1:0]}
                   - {{STAGE_BITS{1'b0}}, w_brw_in};
    assign w_load  = w_en && w_vld_in;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_vld <= 1'b0;
        r_brw <= 1'b0;
        r_dif <= '0;
      end else begin
        if (flush_i) begin
          r_vld <= 1'b0;
        end else if (w_en) begin
          r_vld <= w_vld_in;
        end
        if (w_load) begin
          r_brw <= w_slice[STAGE_BITS];
          r_dif <= w_dif;
        end
      end
    end

    if (k < LAST) begin : g_skew
      // Upper operand slices ride along until their stage comes up.
      logic [REM-STAGE_BITS-1:0] r_a;
      logic [REM-STAGE_BITS-1:0] r_b;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_load) begin
          r_a <= w_a[REM-1:STAGE_BITS];
          r_b <= w_b[REM-1:STAGE_BITS];
        end
      end
    end else begin : g_tail
      // Flags come from the full difference, so they are formed here and
      // registered with it; the outputs stay pure register reads.
      logic r_ovf;
      logic r_zero;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_load) begin
          r_ovf  <= (w_a[REM-1] != w_b[REM-1]) && (w_dif[DONE-1] != w_a[REM-1]);
          r_zero <= (w_dif == '0);
        end
      end
    end
  end

  assign w_out_vld        = g_stage[LAST].r_vld;
  assign s_if.out_valid_o = w_out_vld;
  assign s_if.dif_o       = g_stage[LAST].r_dif;
  assign s_if.brw_o       = g_stage[LAST].r_brw;
  assign s_if.ovf_o       = g_stage[LAST].g_tail.r_ovf;
  assign s_if.zero_o      = g_stage[LAST].g_tail.r_zero;
endmodule

// File: tb/tb_sub_pipe_w.sv
// tb/tb_sub_pipe_w.sv - randomized self-checking bench for sub_pipe_w at slice widths 4, 16 and 1
module tb_sub_pipe_w;
  typedef struct packed {
    logic [15:0] d;
    logic        b;
    logic        o;
    logic        z;
    logic [7:0]  age;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic        brw_s;
  logic [15:0] a_s;
  logic [15:0] b_s;

  logic [2:0]  ov;
  logic [2:0]  ir;
  logic [2:0]  bo;
  logic [2:0]  oo;
  logic [2:0]  zo;
  logic [15:0] dv [3];

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ns_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic void chk(input string name, input int inst, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endfunction

  // Golden result straight from integer arithmetic.
  function automatic ent_t golden(input logic [15:0] a, input logic [15:0] b, input logic bi);
    ent_t e;
    int   ua, ub, sa, sb, r, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = ua - ub - int'(bi);
    s  = sa - sb - int'(bi);
    e.d   = r[15:0];
    e.b   = (ua < ub + int'(bi));
    e.o   = (s < -32768) || (s > 32767);
    e.z   = (r[15:0] == 16'h0000);
    e.age = 8'd0;
    return e;
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int SB = (g == 0) ? 4 : (g == 1) ? 16 : 1;
    localparam int NS = 16 / SB;

    sub_pipe_w_if #(.WIDTH(16)) bus ();

    ent_t q[$];
    ent_t e;
    logic ev;
    logic en;

    assign bus.in_valid_i  = in_valid;
    assign bus.a_i         = a_s;
    assign bus.b_i         = b_s;
    assign bus.brw_i       = brw_s;
    assign bus.out_ready_i = out_ready;
    assign ov[g]           = bus.out_valid_o;
    assign ir[g]           = bus.in_ready_o;
    assign bo[g]           = bus.brw_o;
    assign oo[g]           = bus.ovf_o;
    assign zo[g]           = bus.zero_o;
    assign dv[g]           = bus.dif_o;

    sub_pipe_w #(.WIDTH(16), .STAGE_BITS(SB)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .flush_i(flush),
      .s_if   (bus)
    );

    // Model: each accepted beat must see NS-1 further advancing edges before
    // it is presented; the pipe advances only when the output is free or taken.
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        chk("rst_valid", g, bus.out_valid_o, 1'b0);
        chk("rst_ready", g, bus.in_ready_o, 1'b1);
        chk("rst_dif", g, bus.dif_o, 16'h0000);
        chk("rst_flags", g, {bus.brw_o, bus.ovf_o, bus.zero_o}, 3'b000);
      end else begin
        ev = (q.size() > 0) && (int'(q[0].age) == NS - 1);
        chk("out_valid", g, bus.out_valid_o, ev);
        chk("in_ready", g, bus.in_ready_o, !ev || out_ready);
        if (ev) begin
          chk("dif", g, bus.dif_o, q[0].d);
          chk("brw_o", g, bus.brw_o, q[0].b);
          chk("ovf_o", g, bus.ovf_o, q[0].o);
          chk("zero_o", g, bus.zero_o, q[0].z);
        end
        en = !ev || out_ready;
        if (flush) begin
          q.delete();
        end else if (en) begin
          if (ev) void'(q.pop_front());
          for (int j = 0; j < q.size(); j++) q[j].age = q[j].age + 8'd1;
          if (in_valid) begin
            e = golden(a_s, b_s, brw_s);
            q.push_back(e);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_valid"}, i, ov[i], 1'b0);
      chk({tag, "_ready"}, i, ir[i], 1'b1);
      chk({tag, "_dif"}, i, dv[i], 16'h0000);
      chk({tag, "_flags"}, i, {bo[i], oo[i], zo[i]}, 3'b000);
    end
  endtask

  task automatic send_beats(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a_s       = rand16();
      b_s       = rand16();
      brw_s     = 1'($urandom);
    end
  endtask

  // Called at posedge+1 with an empty pipe; returns at posedge+1.
  task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
    logic [2:0] seen;
    in_valid  = 1'b1;
    a_s       = a;
    b_s       = b;
    brw_s     = bi;
    out_ready = 1'b1;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen     = 3'b000;
    for (int k = 0; k < 40 && seen != 3'b111; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && ov[i]) begin
          seen[i] = 1'b1;
          chk("latency", i, k, ns_of(i) - 1);
          chk("lit_dif", i, dv[i], ed);
          chk("lit_brw", i, bo[i], eb);
          chk("lit_ovf", i, oo[i], eo);
          chk("lit_zero", i, zo[i], ez);
        end
      end
    end
    for (int i = 0; i < 3; i++) chk("emerged", i, seen[i], 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_s       = 16'h0000;
    b_s       = 16'h0000;
    brw_s     = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(4);

    directed(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    directed(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    directed(16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    directed(16'h00F0, 16'h00F0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Eight back-to-back beats with the consumer stalling on cycles 3..5.
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      a_s       = rand16();
      b_s       = rand16();
      brw_s     = 1'($urandom);
      out_ready = !(c >= 3 && c <= 5);
    end
    idle(24);

    // Random traffic with random valid, ready and rare flushes.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a_s       = rand16();
      b_s       = rand16();
      brw_s     = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
    end
    idle(24);

    // Reset with beats in flight.
    send_beats(3);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(24);
    directed(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Flush with beats in flight; a beat offered during the flush is dropped.
    send_beats(3);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a_s      = 16'h5555;
    b_s      = 16'h1111;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    directed(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    idle(24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
